// File: rtl/multicycle_ctrl_pkg.sv
// Shared core definitions: opcodes, aluop encodings, ALU B-mux selects and
// the control FSM state type.
package core_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADDR = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR,
    S_MEMWB, S_EXEC, S_ALUWB, S_BRANCH, S_TRAP
  } ctrl_state_t;

  // States that hold a memory request open until mem_ready
  function automatic logic is_mem_wait(ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified instruction/data memory port handshake.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Saturating wait counter with timeout compare. expired_o fires on the
// MAX-th consecutive busy cycle; MAX = 0 disables it.
module mem_wait_timer #(
  parameter int unsigned MAX = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic busy_i,
  output logic expired_o
);
  localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'((MAX > 0) ? MAX - 1 : 0);

  logic [W-1:0] cnt_q, cnt_d;

  // clear on entry to a wait state, otherwise count busy cycles and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (busy_i && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (MAX != 0) && busy_i && (cnt_q == LAST);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM.
// Optional: define PERF_CNT_EN to add cycle_cnt / instret_cnt outputs.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter logic        RESET_PC_SEL = 1'b0,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  multicycle_ctrl_if.master mem,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  aluop,
  output logic        instr_done,
  output logic        trap
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);
  ctrl_state_t state_q, state_d;
  logic        tmo;

  mem_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_d != state_q),
    .busy_i   (is_mem_wait(state_q) && !mem.mem_ready),
    .expired_o(tmo)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next state and decoded outputs; everything stays quiet while rst_n is low
  always_comb begin
    state_d     = state_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = rst_n ? 1'b0 : RESET_PC_SEL;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RS2;
    aluop       = ALUOP_ADDR;
    instr_done  = 1'b0;
    trap        = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = SRCB_FOUR;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (tmo) state_d = S_TRAP;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BIMM;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R, OP_I:        state_d = S_EXEC;
            OP_BRANCH:         state_d = S_BRANCH;
            default:           state_d = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) state_d = S_MEMWB;
          else if (tmo)      state_d = S_TRAP;
        end
        S_MEMWR: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          mem.mem_we  = 1'b1;
          if (mem.mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (tmo) state_d = S_TRAP;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          if (opcode == OP_R) begin
            alu_src_b = SRCB_RS2;
            aluop     = ALUOP_R;
          end else begin
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_I;
          end
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RS2;
          aluop      = ALUOP_BR;
          pc_write   = zero;
          pc_src     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_TRAP:  trap    = 1'b1;
        default: state_d = S_TRAP;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt_q, ret_cnt_q;

  // performance counters, frozen once trapped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else if (state_q != S_TRAP) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (instr_done) ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_cnt_q;
  assign instret_cnt = ret_cnt_q;
`endif
endmodule
